// File: rtl/mem_stage_access_if.sv
// mem_stage_access_if: word-addressed data-memory request/response bus
interface mem_stage_access_if;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_data;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_data, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_data, mem_ready
    );
endinterface

// File: rtl/mem_stage_access.sv
// mem_stage_access: Y86-64 memory stage that issues data-memory accesses and loads the W register
module mem_stage_access #(
    parameter int MEM_WORDS = 8192,
    parameter int TIMEOUT   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      M_valid,
    input  logic [3:0]                M_stat,
    input  logic [3:0]                M_icode,
    input  logic [63:0]               M_valE,
    input  logic [63:0]               M_valA,
    input  logic [3:0]                M_dstE,
    input  logic [3:0]                M_dstM,
    mem_stage_access_if.master        mem,
    output logic                      m_stall,
    output logic                      W_valid,
    output logic [3:0]                W_stat,
    output logic [3:0]                W_icode,
    output logic [3:0]                W_dstE,
    output logic [3:0]                W_dstM,
    output logic [63:0]               W_valE,
    output logic [63:0]               W_valM
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [3:0] AOK = 4'd1;
    localparam logic [3:0] ADR = 4'd3;
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    l_stat, l_icode, l_dstE, l_dstM;
    logic [63:0]   l_valE;
    logic          l_rd;

    logic          is_wr, is_rd, active, bad;
    logic [63:0]   addr;

    // Decode the M instruction: direction, address source and range check
    always_comb begin
        is_wr  = (M_icode == 4'h4) || (M_icode == 4'h8) || (M_icode == 4'hA);
        is_rd  = (M_icode == 4'h5) || (M_icode == 4'h9) || (M_icode == 4'hB);
        addr   = ((M_icode == 4'h9) || (M_icode == 4'hB)) ? M_valA : M_valE;
        active = M_valid && (M_stat == AOK) && (is_wr || is_rd);
        bad    = addr >= 64'(MEM_WORDS);
    end

    assign m_stall = (state == BUSY);

    // Accept from M in IDLE, wait for ready or timeout in BUSY, then retire into W
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            l_stat        <= AOK;
            l_icode       <= 4'h1;
            l_dstE        <= 4'hF;
            l_dstM        <= 4'hF;
            l_valE        <= '0;
            l_rd          <= 1'b0;
            W_valid       <= 1'b0;
            W_stat        <= AOK;
            W_icode       <= 4'h1;
            W_dstE        <= 4'hF;
            W_dstM        <= 4'hF;
            W_valE        <= '0;
            W_valM        <= '0;
        end else if (state == IDLE) begin
            if (!M_valid) begin
                W_valid <= 1'b0;
                W_stat  <= AOK;
                W_icode <= 4'h1;
                W_dstE  <= 4'hF;
                W_dstM  <= 4'hF;
                W_valE  <= '0;
                W_valM  <= '0;
            end else if (active && !bad) begin
                mem.mem_addr  <= addr;
                mem.mem_wdata <= M_valA;
                mem.mem_read  <= is_rd;
                mem.mem_write <= is_wr;
                l_stat        <= M_stat;
                l_icode       <= M_icode;
                l_dstE        <= M_dstE;
                l_dstM        <= M_dstM;
                l_valE        <= M_valE;
                l_rd          <= is_rd;
                cnt           <= '0;
                state         <= BUSY;
                W_valid       <= 1'b0;
            end else begin
                W_valid <= 1'b1;
                W_stat  <= active ? ADR : M_stat;
                W_icode <= M_icode;
                W_dstE  <= M_dstE;
                W_dstM  <= M_dstM;
                W_valE  <= M_valE;
                W_valM  <= '0;
            end
        end else if (mem.mem_ready || cnt == CW'(TIMEOUT - 1)) begin
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
            state         <= IDLE;
            W_valid       <= 1'b1;
            W_stat        <= mem.mem_ready ? l_stat : ADR;
            W_icode       <= l_icode;
            W_dstE        <= l_dstE;
            W_dstM        <= l_dstM;
            W_valE        <= l_valE;
            W_valM        <= (mem.mem_ready && l_rd) ? mem.mem_data : 64'd0;
        end else begin
            cnt     <= cnt + 1'b1;
            W_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: directed self-checking bench for the memory stage
module tb_mem_stage_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        M_valid;
    logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
    logic [63:0] M_valE, M_valA;
    logic        m_stall, W_valid;
    logic [3:0]  W_stat, W_icode, W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    int          checks = 0;
    int          errors = 0;

    mem_stage_access_if bus ();

    mem_stage_access dut (
        .clk(clk), .rst(rst),
        .M_valid(M_valid), .M_stat(M_stat), .M_icode(M_icode),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .mem(bus),
        .m_stall(m_stall), .W_valid(W_valid), .W_stat(W_stat), .W_icode(W_icode),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic v, input logic [3:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] va,
                         input logic [3:0] de, input logic [3:0] dm);
        M_valid = v; M_stat = st; M_icode = ic;
        M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
    endtask

    task automatic bubble();
        set_m(1'b0, 4'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        bus.mem_data = 64'd0;
        bubble();
        tick();
        tick();
        chk("rst_W_valid", 64'(W_valid), 64'd0);
        chk("rst_W_icode", 64'(W_icode), 64'd1);
        chk("rst_W_stat", 64'(W_stat), 64'd1);
        chk("rst_W_dstE", 64'(W_dstE), 64'hF);
        chk("rst_stall", 64'(m_stall), 64'd0);
        chk("rst_read", 64'(bus.mem_read), 64'd0);
        rst = 1'b0;

        // mrmovq, ready on first BUSY cycle
        set_m(1'b1, 4'd1, 4'h5, 64'h10, 64'd0, 4'hF, 4'd3);
        tick();
        chk("mr_read", 64'(bus.mem_read), 64'd1);
        chk("mr_addr", bus.mem_addr, 64'h10);
        chk("mr_stall", 64'(m_stall), 64'd1);
        chk("mr_W_valid0", 64'(W_valid), 64'd0);
        bus.mem_ready = 1'b1;
        bus.mem_data = 64'hDEADBEEF;
        tick();
        chk("mr_read_off", 64'(bus.mem_read), 64'd0);
        chk("mr_stall_off", 64'(m_stall), 64'd0);
        chk("mr_W_valid", 64'(W_valid), 64'd1);
        chk("mr_W_valM", W_valM, 64'hDEADBEEF);
        chk("mr_W_stat", 64'(W_stat), 64'd1);
        chk("mr_W_dstM", 64'(W_dstM), 64'd3);
        bus.mem_ready = 1'b0;
        bubble();
        tick();
        chk("bub_W_valid", 64'(W_valid), 64'd0);
        chk("bub_W_icode", 64'(W_icode), 64'd1);

        // pushq, ready after 3 cycles
        set_m(1'b1, 4'd1, 4'hA, 64'h1FF0, 64'h55, 4'd4, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("push_write", 64'(bus.mem_write), 64'd1);
            chk("push_wdata", bus.mem_wdata, 64'h55);
            chk("push_read", 64'(bus.mem_read), 64'd0);
            chk("push_stall", 64'(m_stall), 64'd1);
        end
        chk("push_addr", bus.mem_addr, 64'h1FF0);
        bus.mem_ready = 1'b1;
        tick();
        chk("push_write_off", 64'(bus.mem_write), 64'd0);
        chk("push_W_valid", 64'(W_valid), 64'd1);
        chk("push_W_valM", W_valM, 64'd0);
        chk("push_W_valE", W_valE, 64'h1FF0);
        bus.mem_ready = 1'b0;
        bubble();
        tick();

        // rmmovq out of range
        set_m(1'b1, 4'd1, 4'h4, 64'd8192, 64'd7, 4'hF, 4'hF);
        tick();
        chk("oor_write", 64'(bus.mem_write), 64'd0);
        chk("oor_stall", 64'(m_stall), 64'd0);
        chk("oor_W_valid", 64'(W_valid), 64'd1);
        chk("oor_W_stat", 64'(W_stat), 64'd3);
        set_m(1'b1, 4'd1, 4'h4, 64'hFFFF_FFFF_0000_0000, 64'd7, 4'hF, 4'hF);
        tick();
        chk("hi_write", 64'(bus.mem_write), 64'd0);
        chk("hi_stall", 64'(m_stall), 64'd0);
        chk("hi_W_stat", 64'(W_stat), 64'd3);
        chk("hi_W_valid", 64'(W_valid), 64'd1);

        // popq timeout
        set_m(1'b1, 4'd1, 4'hB, 64'h100, 64'h20, 4'd4, 4'd5);
        tick();
        chk("pop_addr", bus.mem_addr, 64'h20);
        for (int i = 0; i < 16; i++) begin
            chk("pop_read_held", 64'(bus.mem_read), 64'd1);
            tick();
        end
        chk("pop_read_drop", 64'(bus.mem_read), 64'd0);
        chk("pop_W_valid", 64'(W_valid), 64'd1);
        chk("pop_W_stat", 64'(W_stat), 64'd3);
        chk("pop_W_valM", W_valM, 64'd0);
        chk("pop_stall", 64'(m_stall), 64'd0);
        bubble();
        tick();
        bus.mem_ready = 1'b1;
        tick();
        chk("late_W_valid", 64'(W_valid), 64'd0);
        chk("late_read", 64'(bus.mem_read), 64'd0);
        chk("late_stall", 64'(m_stall), 64'd0);

        // addq, bubble, ret, halt
        bus.mem_ready = 1'b0;
        set_m(1'b1, 4'd1, 4'h6, 64'd5, 64'd0, 4'd2, 4'hF);
        tick();
        chk("seq_addq_valid", 64'(W_valid), 64'd1);
        chk("seq_addq_valE", W_valE, 64'd5);
        chk("seq_addq_dstE", 64'(W_dstE), 64'd2);
        bubble();
        tick();
        chk("seq_bub_valid", 64'(W_valid), 64'd0);
        set_m(1'b1, 4'd1, 4'h9, 64'h40, 64'd4, 4'd4, 4'hF);
        bus.mem_ready = 1'b1;
        bus.mem_data = 64'h1234;
        tick();
        chk("seq_ret_valid", 64'(W_valid), 64'd0);
        chk("seq_ret_read", 64'(bus.mem_read), 64'd1);
        chk("seq_ret_addr", bus.mem_addr, 64'd4);
        tick();
        chk("seq_ret_done", 64'(W_valid), 64'd1);
        chk("seq_ret_valM", W_valM, 64'h1234);
        chk("seq_ret_icode", 64'(W_icode), 64'd9);
        bus.mem_ready = 1'b0;
        set_m(1'b1, 4'd2, 4'h0, 64'd0, 64'd0, 4'hF, 4'hF);
        tick();
        chk("seq_halt_valid", 64'(W_valid), 64'd1);
        chk("seq_halt_stat", 64'(W_stat), 64'd2);
        chk("seq_halt_icode", 64'(W_icode), 64'd0);
        chk("seq_halt_read", 64'(bus.mem_read), 64'd0);
        set_m(1'b1, 4'd4, 4'h4, 64'h10, 64'd9, 4'hF, 4'hF);
        tick();
        chk("ins_write", 64'(bus.mem_write), 64'd0);
        chk("ins_stall", 64'(m_stall), 64'd0);
        chk("ins_W_stat", 64'(W_stat), 64'd4);
        chk("ins_W_valid", 64'(W_valid), 64'd1);

        // reset during BUSY
        set_m(1'b1, 4'd1, 4'h5, 64'h30, 64'd0, 4'hF, 4'd6);
        tick();
        chk("rb_stall", 64'(m_stall), 64'd1);
        rst = 1'b1;
        tick();
        chk("rb_read", 64'(bus.mem_read), 64'd0);
        chk("rb_stall_off", 64'(m_stall), 64'd0);
        chk("rb_W_valid", 64'(W_valid), 64'd0);
        chk("rb_W_icode", 64'(W_icode), 64'd1);
        rst = 1'b0;
        tick();
        chk("rb2_read", 64'(bus.mem_read), 64'd1);
        chk("rb2_addr", bus.mem_addr, 64'h30);
        bus.mem_ready = 1'b1;
        bus.mem_data = 64'hABC;
        tick();
        chk("rb2_W_valid", 64'(W_valid), 64'd1);
        chk("rb2_W_valM", W_valM, 64'hABC);
        chk("rb2_W_dstM", 64'(W_dstM), 64'd6);
        bus.mem_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- Y86-64 pipeline memory-stage initiator. Takes the instruction held in the M pipeline register and decides whether it needs a data-memory access. Drives the read/write request side of the word-addressed data memory, waits for the memory's ready response, then loads the W pipeline register.
- Stalls the upstream stages while an access is outstanding.
- Flags address errors and memory timeouts as stat ADR.

Parameters:
- MEM_WORDS, 8192: number of 64-bit memory words. Legal addresses are 0..MEM_WORDS-1 (word index, not byte address).
- TIMEOUT, 16: maximum number of BUSY cycles to wait for mem_ready before aborting the access.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- M_valid  input  1  M register holds a real instruction; 0 means bubble
- M_stat  input  4  status code: 1 AOK, 2 HLT, 3 ADR, 4 INS
- M_icode  input  4  Y86 instruction code
- M_valE  input  64  ALU result
- M_valA  input  64  register operand or store data
- M_dstE  input  4  E destination register; 4'hF means none
- M_dstM  input  4  M destination register; 4'hF means none
- mem_addr  output  64  memory word address (registered)
- mem_wdata  output  64  store data (registered)
- mem_read  output  1  read request (registered)
- mem_write  output  1  write request (registered)
- mem_data  input  64  read data; valid when mem_ready=1
- mem_ready  input  1  memory has completed the current request
- m_stall  output  1  high while an access is outstanding
- W_valid  output  1  W register holds a retired instruction
- W_stat, W_icode, W_dstE, W_dstM  output  4 each  W pipeline fields
- W_valE, W_valM  output  64 each  W pipeline values

Behaviour:
- Access decode:
  - Write ops (address valE, data valA): rmmovq 4, call 8, pushq A.
  - Read ops: mrmovq 5 (address valE); ret 9 and popq B (address valA).
  - All other icodes are non-memory.
- Access is suppressed if M_valid=0 or M_stat≠AOK.
- States are IDLE and BUSY. m_stall = (state==BUSY), driven combinationally from the state register.
- IDLE, on each edge, accepts the M inputs:
  - Bubble: W_valid←0, W_icode←1 (NOP), W_stat←AOK, W_dstE/W_dstM←F, W_valE/W_valM←0.
  - Non-memory op or suppressed access: W fields←M fields, W_valM←0, W_valid←1. Latency 1 cycle.
  - Memory op with address ≥ MEM_WORDS: no request issued. W fields←M fields, W_stat←ADR (3), W_valM←0, W_valid←1.
  - Memory op with legal address:
    - Register mem_addr and mem_wdata (M_valA).
    - Set exactly one of mem_read/mem_write.
    - Latch the instruction fields internally; clear the timeout counter; state←BUSY.
    - W_valid←0 at this edge.
- BUSY:
  - mem_read, mem_write, mem_addr and mem_wdata are held stable. M inputs are ignored; upstream holds them because m_stall=1.
  - mem_ready=1 at an edge:
    - Deassert mem_read/mem_write.
    - W←latched fields, W_valM←mem_data for reads or 0 for writes, W_stat←latched stat.
    - W_valid←1; state←IDLE.
    - Minimum memory-op latency is 2 edges: the accept edge and the ready edge.
  - mem_ready=0 with counter = TIMEOUT-1:
    - Deassert the request.
    - Retire with W_stat←ADR, W_valM←0, W_valid←1; state←IDLE.
  - Otherwise: counter increments and W_valid←0.
- mem_ready seen while in IDLE is ignored.
- After any retire, the next IDLE edge accepts a new instruction. There are no back-to-back requests without one IDLE cycle, so the request strobes drop for at least one cycle between accesses.
- Reset (also mid-access):
  - State←IDLE; mem_read/mem_write←0; mem_addr/mem_wdata←0.
  - W_valid←0, W_stat←AOK, W_icode←1, W_dstE/W_dstM←F, W_valE/W_valM←0; counter←0.
  - An outstanding access is abandoned and no W update occurs for it.
- Widths: address comparison is an unsigned 64-bit comparison. Addresses with high bits set are out of range, never truncated.

Test Plan:
- mrmovq, M_valE=0x10, memory returns 0xDEADBEEF with mem_ready on the first BUSY cycle -> mem_read=1 and mem_addr=0x10 for 1 cycle; m_stall=1 for 1 cycle; then W_valM=0xDEADBEEF, W_valid=1, W_stat=1.
- pushq, M_valE=0x1FF0 (in range), M_valA=0x55, ready after 3 cycles -> mem_write=1, mem_wdata=0x55 held for 3 cycles; W_valM=0; no mem_read.
- rmmovq, M_valE=8192 -> no request strobe; W_stat=3 on the next edge; m_stall never asserted. Repeat with M_valE=0xFFFF_FFFF_0000_0000 -> same result.
- popq with mem_ready held 0 -> request held exactly 16 cycles, then dropped; W_stat=3, W_valM=0. A later mem_ready pulse is ignored.
- Sequence addq (icode 6), bubble, ret (M_valA=4, ready immediately), halt with M_stat=2 -> W_valid pattern 1,0,0,1,1. ret reads address 4. halt (icode 0) passes through with stat 2 and issues no access. Also present rmmovq with M_stat=4 -> no write, stat 4 passed through.
- Assert rst during BUSY -> next edge: mem_read=0, m_stall=0, W_valid=0, W_icode=1. A following mrmovq completes normally.
